// File: rtl/fpu_arbiter.sv
// Round-robin arbiter and per-op latency sequencer sharing one multi-cycle FPU between two issue ports.
// Optional build macro FPU_PERF_CNT_EN adds the perf_ops/perf_wait activity counters.
module fpu_arbiter #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            req0,
  input  logic [OP_W-1:0] op0,
  input  logic            req1,
  input  logic [OP_W-1:0] op1,
  input  logic            flush,
  output logic            gnt0,
  output logic            gnt1,
  output logic            fpu_sel,
  output logic            fpu_start,
  output logic [OP_W-1:0] fpu_op,
  output logic            busy,
  output logic            done,
  output logic            done_id
`ifdef FPU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_wait
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OP_W-1:0]  fpu_op_q, fpu_op_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;
  logic [CNT_W-1:0] lat;

  // Busy-cycle count per opcode; zero-latency and unlisted opcodes occupy one cycle.
  function automatic logic [CNT_W-1:0] op_latency(input logic [OP_W-1:0] op);
    logic [CNT_W-1:0] l;
    l = CNT_W'(1);
    case (op)
      OP_W'(0), OP_W'(1): l = CNT_W'(7);
      OP_W'(2):           l = CNT_W'(5);
      OP_W'(3):           l = CNT_W'(6);
      OP_W'(6):           l = CNT_W'(16);
      OP_W'(8), OP_W'(9): l = CNT_W'(6);
      default:            l = CNT_W'(1);
    endcase
    return l;
  endfunction

  assign lat = op_latency(fpu_op_q);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
      fpu_op_q  <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      fpu_op_q  <= fpu_op_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    fpu_op_d  = fpu_op_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the port that did not win last time is served.
        if (!flush && !clear) begin
          if (req0 && (!req1 || last_id_q)) gnt0 = 1'b1;
          else if (req1)                    gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          fpu_op_d  = gnt1 ? op1 : op0;
          id_d      = gnt1;
          last_id_d = gnt1;
          count_d   = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == lat - CNT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fpu_sel   = (state_q == BUSY);
  assign busy      = fpu_sel;
  assign fpu_start = fpu_sel && (count_q == '0);
  assign fpu_op    = fpu_op_q;
  assign done_id   = done & id_q;

`ifdef FPU_PERF_CNT_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  // Completed ops and requester cycles spent without a grant.
  always_comb begin
    perf_ops_d  = perf_ops_q + 32'(done);
    perf_wait_d = perf_wait_q + 32'((req0 | req1) & ~(gnt0 | gnt1));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      perf_ops_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_wait = perf_wait_q;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: a transaction-level model predicts each cycle, a negedge monitor compares.
// Build with FPU_PERF_CNT_EN defined to also check the performance counters.
module tb_fpu_arbiter;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, flush = 1'b0;
  logic [3:0] op0 = 4'd0, op1 = 4'd0;
  logic       gnt0, gnt1, fpu_sel, fpu_start, busy, done, done_id;
  logic [3:0] fpu_op;
`ifdef FPU_PERF_CNT_EN
  logic [31:0] perf_ops, perf_wait;
`endif

  fpu_arbiter #(.OP_W(4), .CNT_W(5)) dut (
    .clock(clock), .clear(clear),
    .req0(req0), .op0(op0), .req1(req1), .op1(op1), .flush(flush),
    .gnt0(gnt0), .gnt1(gnt1), .fpu_sel(fpu_sel), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .busy(busy), .done(done), .done_id(done_id)
`ifdef FPU_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_wait(perf_wait)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        g0, g1, bsy, start, dn, did;
    logic [3:0]  op;
    bit          chk_op;
    logic [31:0] p_ops, p_wait;
  } exp_t;

  exp_t cq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference latency table indexed by opcode.
  int lat_tab [16] = '{7, 7, 5, 6, 1, 1, 16, 1, 6, 6, 1, 1, 1, 1, 1, 1};

  // Model state: remaining busy cycles (0 = idle), cycles elapsed, owner, last winner.
  int         m_rem = 0, m_elapsed = 0, m_id = 0, m_last = 1;
  logic [3:0] m_op = 4'd0;
  int         m_ops = 0, m_wait = 0;
  bit         d_req0 = 0, d_req1 = 0, d_flush = 0;
  logic [3:0] d_op0 = 4'd0, d_op1 = 4'd0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (cq.size() > 0) begin
      mon_e = cq.pop_front();
      cmp("gnt0", 32'(gnt0), 32'(mon_e.g0));
      cmp("gnt1", 32'(gnt1), 32'(mon_e.g1));
      cmp("busy", 32'(busy), 32'(mon_e.bsy));
      cmp("fpu_sel", 32'(fpu_sel), 32'(mon_e.bsy));
      cmp("fpu_start", 32'(fpu_start), 32'(mon_e.start));
      cmp("done", 32'(done), 32'(mon_e.dn));
      if (mon_e.dn) cmp("done_id", 32'(done_id), 32'(mon_e.did));
      if (mon_e.chk_op) cmp("fpu_op", 32'(fpu_op), 32'(mon_e.op));
`ifdef FPU_PERF_CNT_EN
      cmp("perf_ops", perf_ops, mon_e.p_ops);
      cmp("perf_wait", perf_wait, mon_e.p_wait);
`endif
    end
  end

  // One clock cycle: apply driver values, predict outputs, advance the model.
  task automatic step();
    exp_t e;
    int   g;
    @(posedge clock);
    #1;
    req0 = d_req0; op0 = d_op0; req1 = d_req1; op1 = d_op1; flush = d_flush;
    e = '{default: '0};
    e.p_ops  = 32'(m_ops);
    e.p_wait = 32'(m_wait);
    g = -1;
    if (m_rem == 0) begin
      if (!d_flush) begin
        if (d_req0 && d_req1) g = 1 - m_last;
        else if (d_req0)      g = 0;
        else if (d_req1)      g = 1;
      end
    end else begin
      e.bsy    = 1'b1;
      e.start  = (m_elapsed == 0);
      e.chk_op = 1'b1;
      e.op     = m_op;
      if (!d_flush && m_rem == 1) begin
        e.dn  = 1'b1;
        e.did = m_id[0];
        m_ops++;
      end
    end
    e.g0 = (g == 0);
    e.g1 = (g == 1);
    if ((d_req0 || d_req1) && g < 0) m_wait++;
    cq.push_back(e);
    if (m_rem > 0) begin
      if (d_flush || m_rem == 1) m_rem = 0;
      else begin
        m_rem--;
        m_elapsed++;
      end
    end else if (g >= 0) begin
      m_op      = (g == 0) ? d_op0 : d_op1;
      m_rem     = lat_tab[m_op];
      m_elapsed = 0;
      m_id      = g;
      m_last    = g;
      if (g == 0) d_req0 = 0;
      else        d_req1 = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous clear pulse mid-cycle; outputs must be zero before the next edge.
  task automatic async_clear(input bit hold_req);
    exp_t e;
    @(posedge clock);
    #1;
    flush = 0; d_flush = 0; d_req0 = 0; d_req1 = 0;
    req0 = hold_req; req1 = hold_req; op0 = 4'd3; op1 = 4'd6;
    #1 clear = 1'b1;
    e = '{default: '0};
    e.chk_op = 1'b1;
    cq.push_back(e);
    m_rem = 0; m_elapsed = 0; m_last = 1; m_ops = 0; m_wait = 0;
    @(negedge clock);
    #1;
    clear = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    // Reset with both requesters raised: no grant may leak through.
    async_clear(1'b1);

    // Single op on port 0, latency 5.
    d_req0 = 1; d_op0 = 4'd2;
    run(8);

    // Contention right after reset: port 0 first, then port 1, then port 0 again.
    async_clear(1'b0);
    d_req0 = 1; d_op0 = 4'd5; d_req1 = 1; d_op1 = 4'd6;
    run(3);
    d_req0 = 1; d_op0 = 4'd5;
    run(22);

    // Zero-latency and unlisted opcodes.
    d_req0 = 1; d_op0 = 4'd4;
    run(3);
    d_req1 = 1; d_op1 = 4'd15;
    run(3);

    // Flush of a long op, then a fresh request in the following cycle.
    async_clear(1'b0);
    d_req0 = 1; d_op0 = 4'd6;
    step();
    run(3);
    d_flush = 1;
    step();
    d_flush = 0; d_req0 = 1; d_op0 = 4'd0;
    step();
    d_req1 = 1; d_op1 = 4'd3;
    run(16);

    // Flush while idle with a pending request, and flush on a would-be done cycle.
    d_flush = 1; d_req0 = 1; d_op0 = 4'd5;
    step();
    d_flush = 0;
    step();
    d_flush = 1;
    step();
    d_flush = 0;
    run(3);

    // Async clear in the 3rd busy cycle of a 7-cycle op, then dual request.
    d_req0 = 1; d_op0 = 4'd0;
    run(3);
    async_clear(1'b0);
    d_req0 = 1; d_op0 = 4'd7; d_req1 = 1; d_op1 = 4'd2;
    run(12);

    // Randomized traffic with held requests and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      if (!d_req0 && $urandom_range(0, 2) == 0) begin d_req0 = 1; d_op0 = 4'($urandom); end
      if (!d_req1 && $urandom_range(0, 2) == 0) begin d_req1 = 1; d_op1 = 4'($urandom); end
      d_flush = ($urandom_range(0, 24) == 0);
      step();
    end
    d_flush = 0; d_req0 = 0; d_req1 = 0;
    run(20);

    // Final clear returns everything, including the counters, to zero.
    async_clear(1'b0);
    run(2);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
